// File: rtl/pll_video_pkg.sv
// Shared definitions for the video PLL reconfiguration sequencer: register map,
// counter-word layout, FSM encoding and the per-mode configuration table.
package pll_video_pkg;

    localparam int NUM_WRITES = 8;

    localparam logic [5:0] ADDR_MODE  = 6'h00;
    localparam logic [5:0] ADDR_START = 6'h02;
    localparam logic [5:0] ADDR_N     = 6'h03;
    localparam logic [5:0] ADDR_M     = 6'h04;
    localparam logic [5:0] ADDR_C     = 6'h05;
    localparam logic [5:0] ADDR_K     = 6'h07;
    localparam logic [5:0] ADDR_BW    = 6'h08;
    localparam logic [5:0] ADDR_CP    = 6'h09;

    localparam int CNT_LO_LSB     = 0;
    localparam int CNT_HI_LSB     = 8;
    localparam int CNT_BYPASS_BIT = 16;
    localparam int CNT_ODD_BIT    = 17;
    localparam int CNT_CSEL_LSB   = 18;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WRITE     = 3'd1,
        ST_WAIT_MASK = 3'd2,
        ST_WAIT_LOCK = 3'd3,
        ST_DONE      = 3'd4,
        ST_ERROR     = 3'd5
    } state_t;

    typedef struct packed {
        logic [31:0] m;
        logic [31:0] n;
        logic [31:0] c0;
        logic [31:0] k;
        logic [31:0] bw;
        logic [31:0] cp;
    } mode_cfg_t;

    // C counter select is left at 0 so every C word addresses C0.
    function automatic logic [31:0] cnt_word(input logic [7:0] hi, input logic [7:0] lo,
                                             input logic bypass, input logic odd);
        logic [31:0] w;
        w = '0;
        w[CNT_LO_LSB +: 8]  = lo;
        w[CNT_HI_LSB +: 8]  = hi;
        w[CNT_BYPASS_BIT]   = bypass;
        w[CNT_ODD_BIT]      = odd;
        w[CNT_CSEL_LSB +: 5] = 5'd0;
        return w;
    endfunction

    localparam mode_cfg_t MODE_TABLE [0:3] = '{
        '{cnt_word(8'd6, 8'd5, 1'b0, 1'b1), cnt_word(8'd0, 8'd0, 1'b1, 1'b0),
          cnt_word(8'd5, 8'd4, 1'b0, 1'b1), 32'h851E_B852, 32'h6, 32'h3},
        '{cnt_word(8'd4, 8'd4, 1'b0, 1'b0), cnt_word(8'd0, 8'd0, 1'b1, 1'b0),
          cnt_word(8'd3, 8'd3, 1'b0, 1'b0), 32'h28F5_C28F, 32'h7, 32'h2},
        '{cnt_word(8'd8, 8'd7, 1'b0, 1'b1), cnt_word(8'd1, 8'd1, 1'b0, 1'b0),
          cnt_word(8'd2, 8'd2, 1'b0, 1'b0), 32'h0000_0000, 32'h6, 32'h3},
        '{cnt_word(8'd10, 8'd10, 1'b0, 1'b0), cnt_word(8'd0, 8'd0, 1'b1, 1'b0),
          cnt_word(8'd1, 8'd1, 1'b0, 1'b0), 32'h8000_0000, 32'h8, 32'h4}
    };

endpackage

// File: rtl/pll_video_mode_rom.sv
// Combinational lookup of the management write (address, data) for a given
// mode and step of the fixed eight-write reconfiguration sequence.
module pll_video_mode_rom
    import pll_video_pkg::*;
(
    input  logic [1:0]  mode_idx,
    input  logic [2:0]  step,
    output logic [5:0]  addr,
    output logic [31:0] data
);

    mode_cfg_t cfg;

    always_comb begin
        cfg  = MODE_TABLE[mode_idx];
        addr = ADDR_MODE;
        data = '0;
        case (step)
            3'd0: begin addr = ADDR_MODE;  data = '0;     end
            3'd1: begin addr = ADDR_M;     data = cfg.m;  end
            3'd2: begin addr = ADDR_N;     data = cfg.n;  end
            3'd3: begin addr = ADDR_C;     data = cfg.c0; end
            3'd4: begin addr = ADDR_K;     data = cfg.k;  end
            3'd5: begin addr = ADDR_BW;    data = cfg.bw; end
            3'd6: begin addr = ADDR_CP;    data = cfg.cp; end
            default: begin addr = ADDR_START; data = '0; end
        endcase
    end

endmodule

// File: rtl/pll_video_reconf_seq.sv
// Sequencer that reprograms a fractional video PLL through its management port
// and waits (masked, then with timeout) for lock.
module pll_video_reconf_seq
    import pll_video_pkg::*;
#(
    parameter int NUM_MODES    = 4,
    parameter int LOCK_TIMEOUT = 1000000,
    parameter int LOCK_MASK    = 16
) (
    input  logic        refclk,
    input  logic        rst_n,
    input  logic        mode_req,
    input  logic [1:0]  mode_sel,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  cur_mode,
    output logic [5:0]  mgmt_address,
    output logic        mgmt_write,
    output logic [31:0] mgmt_writedata,
    input  logic        mgmt_waitrequest,
    input  logic        pll_locked,
    output logic [2:0]  dbg_state
);

    // Management handshake: a write is presented while mgmt_write = 1 and holds
    // address/data unchanged until a cycle with mgmt_waitrequest = 0 accepts it.

    localparam logic [2:0]  LAST_STEP    = 3'(NUM_WRITES - 1);
    localparam logic [19:0] MASK_LAST    = 20'(LOCK_MASK - 1);
    localparam logic [19:0] TIMEOUT_LAST = 20'(LOCK_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [1:0]  mode_q, mode_d;
    logic [1:0]  cur_mode_q, cur_mode_d;
    logic        err_q, err_d;
    logic        cfg_valid_q, cfg_valid_d;
    logic [2:0]  step_q, step_d;
    logic [19:0] cnt_q, cnt_d;

    logic [5:0]  rom_addr;
    logic [31:0] rom_data;

    pll_video_mode_rom u_rom (
        .mode_idx (mode_q),
        .step     (step_q),
        .addr     (rom_addr),
        .data     (rom_data)
    );

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mode_q      <= '0;
            cur_mode_q  <= '0;
            err_q       <= 1'b0;
            cfg_valid_q <= 1'b0;
            step_q      <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            cur_mode_q  <= cur_mode_d;
            err_q       <= err_d;
            cfg_valid_q <= cfg_valid_d;
            step_q      <= step_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        cur_mode_d  = cur_mode_q;
        err_d       = err_q;
        cfg_valid_d = cfg_valid_q;
        step_d      = step_q;
        cnt_d       = (cnt_q == 20'hF_FFFF) ? cnt_q : cnt_q + 20'd1;

        case (state_q)
            ST_IDLE: begin
                if (mode_req) begin
                    mode_d = mode_sel;
                    err_d  = 1'b0;
                    if (int'(mode_sel) >= NUM_MODES) begin
                        state_d = ST_ERROR;
                        err_d   = 1'b1;
                    end else if (mode_sel == cur_mode_q && !err_q && cfg_valid_q) begin
                        state_d = ST_DONE;
                    end else begin
                        // PLL contents are in flux from the first write on.
                        state_d     = ST_WRITE;
                        step_d      = '0;
                        cfg_valid_d = 1'b0;
                    end
                end
            end
            ST_WRITE: begin
                if (!mgmt_waitrequest) begin
                    if (step_q == LAST_STEP) begin
                        state_d = ST_WAIT_MASK;
                        cnt_d   = '0;
                    end else begin
                        step_d = step_q + 3'd1;
                    end
                end
            end
            ST_WAIT_MASK: begin
                if (cnt_q >= TIMEOUT_LAST) begin
                    state_d = ST_ERROR;
                    err_d   = 1'b1;
                end else if (cnt_q >= MASK_LAST) begin
                    state_d = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                if (pll_locked) begin
                    state_d     = ST_DONE;
                    cur_mode_d  = mode_q;
                    cfg_valid_d = 1'b1;
                end else if (cnt_q >= TIMEOUT_LAST) begin
                    state_d = ST_ERROR;
                    err_d   = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_ERROR: begin
                state_d = ST_IDLE;
                err_d   = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy           = (state_q == ST_WRITE) || (state_q == ST_WAIT_MASK) ||
                            (state_q == ST_WAIT_LOCK);
    assign done           = (state_q == ST_DONE);
    assign err            = err_q;
    assign cur_mode       = cur_mode_q;
    assign mgmt_write     = (state_q == ST_WRITE);
    assign mgmt_address   = mgmt_write ? rom_addr : '0;
    assign mgmt_writedata = mgmt_write ? rom_data : '0;
    assign dbg_state      = state_q;

endmodule
